// File: rtl/hd44780_pkg.sv
// Shared constants, types and address helpers for the HD44780 responder.
// DDRAM is stored linearly: line 0 (0x00-0x27) at 0..39, line 1 (0x40-0x67) at 40..79.
package hd44780_pkg;

    localparam logic [6:0] LINE0_BASE  = 7'h00;
    localparam logic [6:0] LINE0_LIMIT = 7'h27;
    localparam logic [6:0] LINE1_BASE  = 7'h40;
    localparam logic [6:0] LINE1_LIMIT = 7'h67;
    localparam int         LINE_LEN    = 40;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    localparam logic [7:0] MASK_CLEAR   = 8'h01;
    localparam logic [7:0] MASK_HOME    = 8'h02;
    localparam logic [7:0] MASK_ENTRY   = 8'h04;
    localparam logic [7:0] MASK_DISPLAY = 8'h08;
    localparam logic [7:0] MASK_SHIFT   = 8'h10;
    localparam logic [7:0] MASK_FUNC    = 8'h20;
    localparam logic [7:0] MASK_CGRAM   = 8'h40;
    localparam logic [7:0] MASK_DDRAM   = 8'h80;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   dl;
        logic   f;
        logic   entry_inc;
    } dbg_t;

    // Instruction class is picked by the most significant set bit.
    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        if ((b & MASK_DDRAM) != 8'h00)        c = CMD_DDRAM;
        else if ((b & MASK_CGRAM) != 8'h00)   c = CMD_CGRAM;
        else if ((b & MASK_FUNC) != 8'h00)    c = CMD_FUNC;
        else if ((b & MASK_SHIFT) != 8'h00)   c = CMD_SHIFT;
        else if ((b & MASK_DISPLAY) != 8'h00) c = CMD_DISPLAY;
        else if ((b & MASK_ENTRY) != 8'h00)   c = CMD_ENTRY;
        else if ((b & MASK_HOME) != 8'h00)    c = CMD_HOME;
        else if ((b & MASK_CLEAR) != 8'h00)   c = CMD_CLEAR;
        else                                  c = CMD_NOP;
        return c;
    endfunction

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= LINE0_LIMIT) || ((a >= LINE1_BASE) && (a <= LINE1_LIMIT));
    endfunction

    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        logic [6:0] idx;
        if (a < LINE1_BASE) idx = a;
        else                idx = a - LINE1_BASE + 7'(LINE_LEN);
        return idx;
    endfunction

    function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == LINE0_LIMIT)      n = LINE1_BASE;
            else if (a == LINE1_LIMIT) n = LINE0_BASE;
            else                       n = a + 7'd1;
        end else begin
            if (a == LINE0_BASE)       n = LINE1_LIMIT;
            else if (a == LINE1_BASE)  n = LINE0_LIMIT;
            else                       n = a - 7'd1;
        end
        return n;
    endfunction

    // Holes between and after the two lines snap to the start of the next line.
    function automatic logic [6:0] normalize_addr(input logic [6:0] a);
        logic [6:0] n;
        if ((a > LINE0_LIMIT) && (a < LINE1_BASE)) n = LINE1_BASE;
        else if (a > LINE1_LIMIT)                  n = LINE0_BASE;
        else                                       n = a;
        return n;
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 80x8 display RAM: port A synchronous write / asynchronous read for the bus
// and clear engine, port B registered read for the scan port.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we_a,
    input  logic [6:0] i_idx_a,
    input  logic [7:0] i_wdata_a,
    output logic [7:0] o_rdata_a,
    input  logic [6:0] i_idx_b,
    input  logic       i_valid_b,
    output logic [7:0] o_q_b
);

    logic [7:0] r_mem [DDRAM_DEPTH];
    logic [7:0] r_q_b;

    always_ff @(posedge i_clk) begin
        if (i_we_a) begin
            r_mem[i_idx_a] <= i_wdata_a;
        end
    end

    assign o_rdata_a = r_mem[i_idx_a];

    // Read-before-write: a location being cleared this cycle still shows its old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q_b <= 8'h00;
        end else if (i_valid_b) begin
            r_q_b <= r_mem[i_idx_b];
        end else begin
            r_q_b <= BLANK_CHAR;
        end
    end

    assign o_q_b = r_q_b;

endmodule

// File: rtl/hd44780_responder.sv
// HD44780 controller-side bus responder: synchronizes the E/RS/RW/DB pins,
// executes the 8-bit instruction set with busy timing, and serves reads and a scan port.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int EXEC_CYCLES    = 37,
    parameter int CLEAR_CYCLES   = 1520,
    parameter int POWERUP_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_clk,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       ovr_err,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_char,
    output dbg_t       dbg
);

    localparam logic [15:0] EXEC_LOAD    = 16'(EXEC_CYCLES - 1);
    localparam logic [15:0] CLEAR_LOAD   = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] POWERUP_LOAD = 16'(POWERUP_CYCLES - 2);

    // Bus handshake: the host holds RS/RW/DB stable around E. A write is taken on
    // the synchronized E falling edge; a read drives DB from E rising until E falling.
    logic [10:0] r_sync1;
    logic [10:0] r_sync2;
    logic        r_e3;

    logic        w_e;
    logic        w_rs;
    logic        w_rw;
    logic [7:0]  w_db;
    logic        w_e_rise;
    logic        w_e_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_e3    <= 1'b0;
        end else begin
            r_sync1 <= {lcd_clk, lcd_rs, lcd_rw, lcd_data_in};
            r_sync2 <= r_sync1;
            r_e3    <= r_sync2[10];
        end
    end

    assign w_e      = r_sync2[10];
    assign w_rs     = r_sync2[9];
    assign w_rw     = r_sync2[8];
    assign w_db     = r_sync2[7:0];
    assign w_e_rise = w_e & ~r_e3;
    assign w_e_fall = ~w_e & r_e3;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_busy;
    logic [15:0] r_cnt;
    logic [6:0]  r_ac;
    logic        r_inc;
    logic        r_disp;
    logic        r_cur;
    logic        r_blink;
    logic        r_two;
    logic        r_dl;
    logic        r_f;
    logic        r_ovr;
    logic        r_oe;
    logic [7:0]  r_dout;
    logic [6:0]  r_clr_idx;

    logic        w_wr_acc;
    logic        w_wr_rej;
    logic        w_rd_rise;
    logic        w_drd_acc;
    logic        w_drd_rej;
    cmd_t        w_cmd;
    logic        w_busy_load;
    logic [15:0] w_busy_val;

    logic        w_we_a;
    logic [6:0]  w_idx_a;
    logic [7:0]  w_wdata_a;
    logic [7:0]  w_rdata_a;
    logic [7:0]  w_scan_q;

    assign w_wr_acc  = w_e_fall & ~w_rw & ~r_busy;
    assign w_wr_rej  = w_e_fall & ~w_rw & r_busy;
    assign w_rd_rise = w_e_rise & w_rw;
    assign w_drd_acc = w_rd_rise & w_rs & ~r_busy;
    assign w_drd_rej = w_rd_rise & w_rs & r_busy;
    assign w_cmd     = decode_cmd(w_db);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_load = 1'b0;
        w_busy_val  = EXEC_LOAD;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_CLEAR;
                w_busy_load = 1'b1;
                w_busy_val  = POWERUP_LOAD;
            end
            ST_CLEAR: begin
                if (r_clr_idx == 7'(DDRAM_DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_wr_acc && !w_rs && (w_cmd == CMD_CLEAR)) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (w_wr_acc) begin
            w_busy_load = 1'b1;
            if (!w_rs && ((w_cmd == CMD_CLEAR) || (w_cmd == CMD_HOME))) begin
                w_busy_val = CLEAR_LOAD;
            end
        end else if (w_drd_acc) begin
            w_busy_load = 1'b1;
        end
    end

    // The clear engine owns port A while active; the host cannot write then since busy is set.
    always_comb begin
        w_we_a    = 1'b0;
        w_idx_a   = addr_to_idx(r_ac);
        w_wdata_a = w_db;
        if (r_state == ST_CLEAR) begin
            w_we_a    = 1'b1;
            w_idx_a   = r_clr_idx;
            w_wdata_a = BLANK_CHAR;
        end else if (w_wr_acc && w_rs) begin
            w_we_a = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_ac      <= '0;
            r_inc     <= 1'b1;
            r_disp    <= 1'b0;
            r_cur     <= 1'b0;
            r_blink   <= 1'b0;
            r_two     <= 1'b0;
            r_dl      <= 1'b0;
            r_f       <= 1'b0;
            r_ovr     <= 1'b0;
            r_oe      <= 1'b0;
            r_dout    <= '0;
            r_clr_idx <= '0;
        end else begin
            if (w_busy_load) begin
                r_busy <= 1'b1;
                r_cnt  <= w_busy_val;
            end else if (r_busy) begin
                if (r_cnt == 16'd0) r_busy <= 1'b0;
                else                r_cnt  <= r_cnt - 16'd1;
            end

            if ((w_state_nxt == ST_CLEAR) && (r_state != ST_CLEAR)) begin
                r_clr_idx <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + 7'd1;
            end

            if (w_wr_rej || w_drd_rej) begin
                r_ovr <= 1'b1;
            end

            if (w_wr_acc) begin
                if (w_rs) begin
                    r_ac <= ac_next(r_ac, r_inc);
                end else begin
                    case (w_cmd)
                        CMD_CLEAR: begin
                            r_ac  <= LINE0_BASE;
                            r_inc <= 1'b1;
                        end
                        CMD_HOME:    r_ac <= LINE0_BASE;
                        CMD_ENTRY:   r_inc <= w_db[1];
                        CMD_DISPLAY: begin
                            r_disp  <= w_db[2];
                            r_cur   <= w_db[1];
                            r_blink <= w_db[0];
                        end
                        CMD_SHIFT: begin
                            if (!w_db[3]) r_ac <= ac_next(r_ac, w_db[2]);
                        end
                        CMD_FUNC: begin
                            r_dl  <= w_db[4];
                            r_two <= w_db[3];
                            r_f   <= w_db[2];
                        end
                        CMD_DDRAM:   r_ac <= normalize_addr(w_db[6:0]);
                        default: ;
                    endcase
                end
            end else if (w_drd_acc) begin
                r_ac <= ac_next(r_ac, r_inc);
            end

            if (w_rd_rise) begin
                r_oe <= 1'b1;
                if (!w_rs)       r_dout <= {r_busy, r_ac};
                else if (r_busy) r_dout <= 8'h00;
                else             r_dout <= w_rdata_a;
            end else if (w_e_fall && w_rw) begin
                r_oe <= 1'b0;
            end
        end
    end

    hd44780_ddram u_ddram (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we_a    (w_we_a),
        .i_idx_a   (w_idx_a),
        .i_wdata_a (w_wdata_a),
        .o_rdata_a (w_rdata_a),
        .i_idx_b   (addr_to_idx(scan_addr)),
        .i_valid_b (addr_valid(scan_addr)),
        .o_q_b     (w_scan_q)
    );

    assign lcd_data_out = r_dout;
    assign lcd_data_oe  = r_oe;
    assign busy         = r_busy;
    assign ac           = r_ac;
    assign disp_on      = r_disp;
    assign cursor_on    = r_cur;
    assign blink_on     = r_blink;
    assign two_line     = r_two;
    assign ovr_err      = r_ovr;
    assign scan_char    = w_scan_q;

    always_comb begin
        dbg           = '0;
        dbg.state     = r_state;
        dbg.dl        = r_dl;
        dbg.f         = r_f;
        dbg.entry_inc = r_inc;
    end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: power-up timing, an instruction table
// with expected AC/flags, then hand sequences for overrun, reads and reset mid-clear.
module tb_hd44780_responder;
    import hd44780_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_clk = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on;
    logic       cursor_on;
    logic       blink_on;
    logic       two_line;
    logic       ovr_err;
    logic [6:0] scan_addr = 7'h00;
    logic [7:0] scan_char;
    dbg_t       dbg;

    int errors = 0;
    int checks = 0;

    hd44780_responder dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_clk      (lcd_clk),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .busy         (busy),
        .ac           (ac),
        .disp_on      (disp_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .two_line     (two_line),
        .ovr_err      (ovr_err),
        .scan_addr    (scan_addr),
        .scan_char    (scan_char),
        .dbg          (dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic [6:0] ac;
        logic [2:0] dcb;
        logic       two;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_not_busy(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 32'(busy), 32'h0);
        cyc(1);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        lcd_rs = rs;
        lcd_rw = 1'b0;
        lcd_data_in = d;
        cyc(1);
        lcd_clk = 1'b0;
        cyc(4);
        lcd_clk = 1'b1;
        cyc(1);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe_hi,
                            output logic bsy, output logic oe_lo);
        lcd_rs = rs;
        lcd_rw = 1'b1;
        cyc(1);
        lcd_clk = 1'b0;
        cyc(4);
        lcd_clk = 1'b1;
        cyc(4);
        @(negedge clk);
        d = lcd_data_out;
        oe_hi = lcd_data_oe;
        bsy = busy;
        cyc(1);
        lcd_clk = 1'b0;
        cyc(4);
        @(negedge clk);
        oe_lo = lcd_data_oe;
        cyc(1);
        lcd_rw = 1'b0;
        cyc(1);
        lcd_clk = 1'b1;
        cyc(4);
    endtask

    task automatic scan_check(input string name, input logic [6:0] a, input logic [7:0] exp);
        scan_addr = a;
        cyc(1);
        @(negedge clk);
        check(name, 32'(scan_char), 32'(exp));
        cyc(1);
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {lcd_data_out, lcd_data_oe, busy, ac, disp_on, cursor_on, blink_on,
                     two_line, ovr_err, scan_char},
              {8'h00, 1'b0, 1'b1, 7'h00, 5'b00000, 8'h00});
        check({name, "_dbg"}, {dbg.state, dbg.entry_inc}, {ST_INIT, 1'b1});
    endtask

    task automatic count_busy(input int window, output int n);
        n = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] d;
        logic       oe_hi;
        logic       oe_lo;
        logic       bsy;
        int         n;

        vecs.push_back('{1'b0, 8'h38, 7'h00, 3'b000, 1'b1});
        vecs.push_back('{1'b0, 8'h0C, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h06, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h01, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'hA6, 7'h26, 3'b100, 1'b1});
        vecs.push_back('{1'b1, 8'h41, 7'h27, 3'b100, 1'b1});
        vecs.push_back('{1'b1, 8'h42, 7'h40, 3'b100, 1'b1});
        vecs.push_back('{1'b1, 8'h43, 7'h41, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h04, 7'h41, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h80, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b1, 8'h5A, 7'h67, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h06, 7'h67, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h14, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h10, 7'h67, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h1C, 7'h67, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'hB0, 7'h40, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h10, 7'h27, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'hF0, 7'h00, 3'b100, 1'b1});
        vecs.push_back('{1'b0, 8'h0B, 7'h00, 3'b011, 1'b1});
        vecs.push_back('{1'b0, 8'h47, 7'h00, 3'b011, 1'b1});
        vecs.push_back('{1'b0, 8'h95, 7'h15, 3'b011, 1'b1});
        vecs.push_back('{1'b0, 8'h02, 7'h00, 3'b011, 1'b1});
        vecs.push_back('{1'b0, 8'h30, 7'h00, 3'b011, 1'b0});
        vecs.push_back('{1'b0, 8'h0E, 7'h00, 3'b110, 1'b0});

        // Clock/reset, then power-up window length.
        #2 rst = 1'b1;
        cyc(3);
        @(negedge clk);
        check_reset_vals("reset");
        cyc(1);
        rst = 1'b0;
        count_busy(10100, n);
        check("powerup_busy_len", n, 10000);
        cyc(1);
        scan_check("pu_scan_00", 7'h00, 8'h20);
        scan_check("pu_scan_67", 7'h67, 8'h20);
        bus_read(1'b0, d, oe_hi, bsy, oe_lo);
        check("pu_status", {oe_hi, d}, {1'b1, 8'h00});

        // Clear instruction busy length, measured from the E falling edge on the pin.
        wait_not_busy("nb_clr");
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
        lcd_data_in = 8'h01;
        cyc(1);
        lcd_clk = 1'b0;
        n = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (i == 4) lcd_clk = 1'b1;
        end
        check("clear_busy_len", n, 1520);
        cyc(1);

        // Instruction / data table.
        foreach (vecs[i]) begin
            wait_not_busy($sformatf("nb_vec%0d", i));
            bus_write(vecs[i].rs, vecs[i].db);
            wait_not_busy($sformatf("nb_post%0d", i));
            check($sformatf("vec%0d", i), {disp_on, cursor_on, blink_on, two_line, ac},
                  {vecs[i].dcb, vecs[i].two, vecs[i].ac});
        end

        scan_check("scan_26", 7'h26, 8'h41);
        scan_check("scan_27", 7'h27, 8'h42);
        scan_check("scan_40", 7'h40, 8'h43);
        scan_check("scan_00", 7'h00, 8'h5A);
        scan_check("scan_67", 7'h67, 8'h20);
        scan_check("scan_hole_30", 7'h30, 8'h20);
        scan_check("scan_hole_7f", 7'h7F, 8'h20);
        scan_addr = 7'h26;
        @(negedge clk);
        check("scan_latency_old", 32'(scan_char), 32'h20);
        @(negedge clk);
        check("scan_latency_new", 32'(scan_char), 32'h41);
        cyc(1);

        // Write while busy is discarded and flagged; status read shows {busy, ac}.
        wait_not_busy("nb_ovr");
        check("ovr_before", 32'(ovr_err), 32'h0);
        bus_write(1'b0, 8'h85);
        bus_write(1'b1, 8'h31);
        check("ovr_set", 32'(ovr_err), 32'h1);
        bus_read(1'b0, d, oe_hi, bsy, oe_lo);
        check("status_busy", 32'(d), 32'h85);
        wait_not_busy("nb_ovr2");
        check("ovr_ac", 32'(ac), 32'h05);
        scan_check("ovr_scan_05", 7'h05, 8'h20);

        // Data read from 0x40, then a data read while busy.
        bus_write(1'b0, 8'hC0);
        wait_not_busy("nb_rd");
        bus_read(1'b1, d, oe_hi, bsy, oe_lo);
        check("drd_data", {oe_hi, bsy, d}, {1'b1, 1'b1, 8'h43});
        check("drd_oe_low", 32'(oe_lo), 32'h0);
        check("drd_ac", 32'(ac), 32'h41);
        bus_read(1'b1, d, oe_hi, bsy, oe_lo);
        check("drd_busy_data", {oe_hi, d}, {1'b1, 8'h00});
        check("drd_busy_ac", 32'(ac), 32'h41);

        // Reset in the middle of a clear.
        wait_not_busy("nb_mid");
        bus_write(1'b0, 8'h01);
        cyc(20);
        check("mid_clear_state", 32'(dbg.state), 32'(ST_CLEAR));
        rst = 1'b1;
        scan_addr = 7'h26;
        cyc(2);
        @(negedge clk);
        check_reset_vals("mid_reset");
        cyc(1);
        rst = 1'b0;
        fork
            begin
                int nb;
                count_busy(10100, nb);
                check("repowerup_busy_len", nb, 10000);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check("clear_old_26", 32'(scan_char), 32'h41);
                cyc(1);
                bus_read(1'b0, d, oe_hi, bsy, oe_lo);
                check("pu_status_busy", 32'(d), 32'h80);
                check("status_no_ovr", 32'(ovr_err), 32'h0);
                bus_read(1'b1, d, oe_hi, bsy, oe_lo);
                check("pu_drd_busy", {d, ovr_err}, {8'h00, 1'b1});
                check("pu_drd_ac", 32'(ac), 32'h00);
            end
        join
        cyc(1);
        scan_check("clear_new_26", 7'h26, 8'h20);
        scan_check("clear_new_40", 7'h40, 8'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
